// File: rtl/qoa_frame_parser_if.sv
// rtl/qoa_frame_parser_if.sv - stream, record and status signals of qoa_frame_parser
// master: parser side (drives in_ready, LMS records, slices, frame status)
// slave:  environment side (drives input words, lms_ready, slice_ready)
interface qoa_frame_parser_if #(
    parameter int MAX_CHANNELS = 2
);
    localparam int CHW = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

    logic [63:0]    in_data;
    logic           in_valid;
    logic           in_ready;

    logic           lms_valid;
    logic           lms_ready;
    logic [CHW-1:0] lms_channel;
    logic [63:0]    lms_history;    // history[i] at bits [63-16*i -: 16]
    logic [63:0]    lms_weights;    // weights[i] at bits [63-16*i -: 16]

    logic           slice_valid;
    logic           slice_ready;
    logic [63:0]    slice_data;
    logic [CHW-1:0] slice_channel;
    logic [4:0]     slice_nsamples;
    logic           slice_last;

    logic [7:0]     frame_channels;
    logic [23:0]    frame_rate;
    logic           frame_done;
    logic           error;

    modport master (
        input  in_data, in_valid, lms_ready, slice_ready,
        output in_ready,
        output lms_valid, lms_channel, lms_history, lms_weights,
        output slice_valid, slice_data, slice_channel, slice_nsamples, slice_last,
        output frame_channels, frame_rate, frame_done, error
    );

    modport slave (
        output in_data, in_valid, lms_ready, slice_ready,
        input  in_ready,
        input  lms_valid, lms_channel, lms_history, lms_weights,
        input  slice_valid, slice_data, slice_channel, slice_nsamples, slice_last,
        input  frame_channels, frame_rate, frame_done, error
    );
endinterface

// File: rtl/qoa_frame_parser.sv
// rtl/qoa_frame_parser.sv - QOA file/frame parser feeding per-channel slice decoders
// Ports:
//   clk, rst  single clock, asynchronous active-high reset
//   bus       qoa_frame_parser_if.master:
//             in_*    big-endian 64-bit stream words
//             lms_*   per-channel LMS history/weights record (single-entry register)
//             slice_* channel-tagged slice word, sample count, last flag (single-entry register)
//             frame_channels/frame_rate of the current frame, frame_done pulse, sticky error
module qoa_frame_parser #(
    parameter int MAX_CHANNELS = 2
) (
    input logic                clk,
    input logic                rst,
    qoa_frame_parser_if.master bus
);
    localparam int          CHW    = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;
    localparam logic [31:0] MAGIC  = 32'h716f6166;
    localparam logic [15:0] MAX_FS = 16'd5120;

    typedef enum logic [2:0] {
        S_FILE_HDR,
        S_FRAME_HDR,
        S_LMS_HIST,
        S_LMS_WGT,
        S_SLICES,
        S_ERROR
    } state_t;

    state_t      state;
    logic [31:0] total_t;      // T from the file header, 0 = streaming
    logic [31:0] rem_r;        // samples still expected in the file
    logic [7:0]  ch_num;
    logic [7:0]  ch_cnt;
    logic [15:0] fs;
    logic [15:0] fsize;
    logic [15:0] grp_rem;      // samples left per channel from the current slice group on
    logic [16:0] byte_cnt;
    logic [63:0] hist_stage;
    logic        end_pending;  // final slice of the frame accepted, waiting for it to drain

    logic        in_rdy;
    logic        in_fire;
    logic        lms_fire;
    logic        slice_fire;
    logic        hdr_bad;
    logic        last_ch;
    logic [7:0]  hdr_ch;
    logic [15:0] hdr_fs;

    assign hdr_ch  = bus.in_data[63:56];
    assign hdr_fs  = bus.in_data[31:16];
    assign hdr_bad = (hdr_ch == 8'd0) || (hdr_ch > 8'(MAX_CHANNELS)) ||
                     (hdr_fs == 16'd0) || (hdr_fs > MAX_FS) ||
                     ((total_t != 32'd0) && ({16'd0, hdr_fs} > rem_r));
    assign last_ch = (ch_cnt == ch_num - 8'd1);

    // Words are only taken when their destination register is empty or draining.
    // While the final slice drains, the next header waits for the state change.
    always_comb begin
        in_rdy = 1'b0;
        case (state)
            S_FILE_HDR, S_FRAME_HDR, S_LMS_HIST: in_rdy = 1'b1;
            S_LMS_WGT: in_rdy = !bus.lms_valid || bus.lms_ready;
            S_SLICES:  in_rdy = !end_pending && (!bus.slice_valid || bus.slice_ready);
            default:   in_rdy = 1'b0;
        endcase
    end

    assign bus.in_ready = in_rdy;
    assign in_fire      = bus.in_valid && in_rdy;
    assign lms_fire     = bus.lms_valid && bus.lms_ready;
    assign slice_fire   = bus.slice_valid && bus.slice_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_FILE_HDR;
            total_t            <= '0;
            rem_r              <= '0;
            ch_num             <= '0;
            ch_cnt             <= '0;
            fs                 <= '0;
            fsize              <= '0;
            grp_rem            <= '0;
            byte_cnt           <= '0;
            hist_stage         <= '0;
            end_pending        <= 1'b0;
            bus.lms_valid      <= 1'b0;
            bus.lms_channel    <= '0;
            bus.lms_history    <= '0;
            bus.lms_weights    <= '0;
            bus.slice_valid    <= 1'b0;
            bus.slice_data     <= '0;
            bus.slice_channel  <= '0;
            bus.slice_nsamples <= '0;
            bus.slice_last     <= 1'b0;
            bus.frame_channels <= '0;
            bus.frame_rate     <= '0;
            bus.frame_done     <= 1'b0;
            bus.error          <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (lms_fire) bus.lms_valid <= 1'b0;
            if (slice_fire) bus.slice_valid <= 1'b0;

            case (state)
                S_FILE_HDR: begin
                    if (in_fire) begin
                        if (bus.in_data[63:32] != MAGIC) begin
                            state     <= S_ERROR;
                            bus.error <= 1'b1;
                        end else begin
                            total_t <= bus.in_data[31:0];
                            rem_r   <= bus.in_data[31:0];
                            state   <= S_FRAME_HDR;
                        end
                    end
                end
                S_FRAME_HDR: begin
                    if (in_fire) begin
                        if (hdr_bad) begin
                            state     <= S_ERROR;
                            bus.error <= 1'b1;
                        end else begin
                            bus.frame_channels <= hdr_ch;
                            bus.frame_rate     <= bus.in_data[55:32];
                            ch_num             <= hdr_ch;
                            fs                 <= hdr_fs;
                            fsize              <= bus.in_data[15:0];
                            ch_cnt             <= '0;
                            byte_cnt           <= 17'd8;
                            state              <= S_LMS_HIST;
                        end
                    end
                end
                S_LMS_HIST: begin
                    if (in_fire) begin
                        hist_stage <= bus.in_data;
                        byte_cnt   <= byte_cnt + 17'd8;
                        state      <= S_LMS_WGT;
                    end
                end
                S_LMS_WGT: begin
                    if (in_fire) begin
                        bus.lms_valid   <= 1'b1;
                        bus.lms_channel <= ch_cnt[CHW-1:0];
                        bus.lms_history <= hist_stage;
                        bus.lms_weights <= bus.in_data;
                        byte_cnt        <= byte_cnt + 17'd8;
                        if (!last_ch) begin
                            ch_cnt <= ch_cnt + 8'd1;
                            state  <= S_LMS_HIST;
                        end else begin
                            ch_cnt  <= '0;
                            grp_rem <= fs;
                            state   <= S_SLICES;
                        end
                    end
                end
                S_SLICES: begin
                    if (end_pending) begin
                        if (slice_fire) begin
                            end_pending    <= 1'b0;
                            bus.frame_done <= 1'b1;
                            rem_r          <= rem_r - {16'd0, fs};
                            if (byte_cnt != {1'b0, fsize}) begin
                                state     <= S_ERROR;
                                bus.error <= 1'b1;
                            end else if ((total_t != 32'd0) && (rem_r == {16'd0, fs})) begin
                                state <= S_FILE_HDR;
                            end else begin
                                state <= S_FRAME_HDR;
                            end
                        end
                    end else if (in_fire) begin
                        bus.slice_valid    <= 1'b1;
                        bus.slice_data     <= bus.in_data;
                        bus.slice_channel  <= ch_cnt[CHW-1:0];
                        bus.slice_nsamples <= (grp_rem >= 16'd20) ? 5'd20 : grp_rem[4:0];
                        bus.slice_last     <= (grp_rem <= 16'd20);
                        byte_cnt           <= byte_cnt + 17'd8;
                        if (last_ch) begin
                            ch_cnt  <= '0;
                            grp_rem <= (grp_rem > 16'd20) ? grp_rem - 16'd20 : 16'd0;
                            if (grp_rem <= 16'd20) end_pending <= 1'b1;
                        end else begin
                            ch_cnt <= ch_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    // Sticky until reset; output registers only drain.
                    state <= S_ERROR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qoa_frame_parser.sv
// tb/tb_qoa_frame_parser.sv - randomized self-checking bench for qoa_frame_parser
module tb_qoa_frame_parser;
    localparam int MAX_CH = 2;
    localparam logic [31:0] MAGIC = 32'h716f6166;

    typedef struct packed {
        logic [7:0]  ch;
        logic [63:0] hist;
        logic [63:0] wgt;
    } lms_rec_t;

    typedef struct packed {
        logic [7:0]  ch;
        logic [63:0] data;
        logic [7:0]  ns;
        logic        last;
    } slice_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qoa_frame_parser_if #(.MAX_CHANNELS(MAX_CH)) bus ();

    qoa_frame_parser #(.MAX_CHANNELS(MAX_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] stim[$];
    lms_rec_t    exp_lms[$];
    slice_rec_t  exp_sl[$];
    int          exp_done;
    int          obs_done;
    int          obs_sl_cnt;
    int          pass_cnt;
    int          total_cnt;
    int          rdy_mode;   // 0 ready, 1 random, 2 slice stalled, 3 slice ready for first slice only
    logic [23:0] last_rate;
    int          last_nch;

    // Downstream ready generator, updated just after each active edge.
    initial begin
        bus.lms_ready   = 1'b0;
        bus.slice_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin bus.lms_ready = 1'b1; bus.slice_ready = 1'b1; end
                1: begin
                    bus.lms_ready   = ($urandom_range(0, 3) != 0);
                    bus.slice_ready = ($urandom_range(0, 3) != 0);
                end
                2: begin bus.lms_ready = 1'b1; bus.slice_ready = 1'b0; end
                default: begin bus.lms_ready = 1'b1; bus.slice_ready = (obs_sl_cnt < 1); end
            endcase
        end
    end

    // Scoreboard: every completed output handshake is matched against the model.
    initial begin
        lms_rec_t   o_l, e_l;
        slice_rec_t o_s, e_s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.lms_valid && bus.lms_ready) begin
                    o_l = {8'(bus.lms_channel), bus.lms_history, bus.lms_weights};
                    total_cnt++;
                    if (exp_lms.size() == 0) begin
                        $display("FAIL lms_unexpected got=%h required=none", o_l);
                    end else begin
                        e_l = exp_lms.pop_front();
                        if (o_l !== e_l) $display("FAIL lms_record got=%h required=%h", o_l, e_l);
                        else pass_cnt++;
                    end
                end
                if (bus.slice_valid && bus.slice_ready) begin
                    o_s = {8'(bus.slice_channel), bus.slice_data, 8'(bus.slice_nsamples), bus.slice_last};
                    obs_sl_cnt++;
                    total_cnt++;
                    if (exp_sl.size() == 0) begin
                        $display("FAIL slice_unexpected got=%h required=none", o_s);
                    end else begin
                        e_s = exp_sl.pop_front();
                        if (o_s !== e_s) $display("FAIL slice_record got=%h required=%h", o_s, e_s);
                        else pass_cnt++;
                    end
                end
                if (bus.frame_done) obs_done++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int pick_fs();
        case ($urandom_range(0, 7))
            0: return 1;
            1: return 19;
            2: return 20;
            3: return 21;
            4: return 40;
            5: return 41;
            default: return $urandom_range(1, 120);
        endcase
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rdy_mode     = 0;
        stim.delete();
        exp_lms.delete();
        exp_sl.delete();
        exp_done   = 0;
        obs_done   = 0;
        obs_sl_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_file_hdr(input logic [31:0] t);
        stim.push_back({MAGIC, t});
    endtask

    // Reference model: a frame is a header, ch (history, weights) pairs, then
    // ceil(fs/20) groups of one slice per channel; a group carries min(20, left) samples.
    task automatic add_frame(input int ch, input int fs, input int fsize_delta);
        int ngrp, fsize, ns;
        logic [23:0] rate;
        logic [63:0] h, w, d;
        ngrp  = (fs + 19) / 20;
        fsize = 8 + ch * 16 + ch * ngrp * 8 + fsize_delta;
        rate  = 24'($urandom);
        stim.push_back({8'(ch), rate, 16'(fs), 16'(fsize)});
        for (int c = 0; c < ch; c++) begin
            h = rnd64();
            w = rnd64();
            stim.push_back(h);
            stim.push_back(w);
            exp_lms.push_back({8'(c), h, w});
        end
        for (int g = 0; g < ngrp; g++) begin
            ns = fs - 20 * g;
            if (ns > 20) ns = 20;
            for (int c = 0; c < ch; c++) begin
                d = rnd64();
                stim.push_back(d);
                exp_sl.push_back({8'(c), d, 8'(ns), (g == ngrp - 1)});
            end
        end
        exp_done++;
        last_rate = rate;
        last_nch  = ch;
    endtask

    task automatic send_all(output bit ok);
        int waitc;
        ok = 1'b1;
        while (stim.size() > 0) begin
            if (rdy_mode == 1 && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.in_data  = stim[0];
            bus.in_valid = 1'b1;
            waitc = 0;
            @(negedge clk);
            while (!bus.in_ready && waitc < 300) begin
                waitc++;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            if (waitc >= 300) begin
                ok = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            void'(stim.pop_front());
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_sl.size() > 0 || exp_lms.size() > 0 || obs_done < exp_done) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); else pass_cnt++;
        total_cnt++; if ({bus.lms_valid, bus.slice_valid, bus.frame_done, bus.error} !== 4'b0)
            $display("FAIL reset_flags got=%b required=0000", {bus.lms_valid, bus.slice_valid, bus.frame_done, bus.error}); else pass_cnt++;
        total_cnt++; if ({bus.frame_channels, bus.frame_rate, bus.slice_data, bus.lms_history} !== '0)
            $display("FAIL reset_data got=%h required=0", {bus.frame_channels, bus.frame_rate, bus.slice_data, bus.lms_history}); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_mono();
        bit ok;
        do_reset();
        add_file_hdr(32'd40);
        add_frame(1, 40, 0);
        // Next file header: only valid if the parser went back to FILE_HDR.
        stim.push_back({MAGIC, 32'd25});
        send_all(ok);
        wait_drain();
        total_cnt++; if (ok !== 1'b1) $display("FAIL mono_send got=stall required=accepted"); else pass_cnt++;
        total_cnt++; if (exp_sl.size() + exp_lms.size() != 0) $display("FAIL mono_left got=%0d required=0", exp_sl.size() + exp_lms.size()); else pass_cnt++;
        total_cnt++; if (obs_done != 1) $display("FAIL mono_done got=%0d required=1", obs_done); else pass_cnt++;
        total_cnt++; if (bus.frame_channels !== 8'd1) $display("FAIL mono_channels got=%0d required=1", bus.frame_channels); else pass_cnt++;
        total_cnt++; if (bus.error !== 1'b0) $display("FAIL mono_file_hdr got=error required=no_error"); else pass_cnt++;
    endtask

    task automatic test_stereo();
        bit ok;
        do_reset();
        add_file_hdr(32'd25);
        add_frame(2, 25, 0);
        send_all(ok);
        wait_drain();
        total_cnt++; if (ok !== 1'b1) $display("FAIL stereo_send got=stall required=accepted"); else pass_cnt++;
        total_cnt++; if (exp_sl.size() + exp_lms.size() != 0) $display("FAIL stereo_left got=%0d required=0", exp_sl.size() + exp_lms.size()); else pass_cnt++;
        total_cnt++; if (obs_done != 1) $display("FAIL stereo_done got=%0d required=1", obs_done); else pass_cnt++;
        total_cnt++; if ({bus.frame_channels, bus.frame_rate} !== {8'd2, last_rate})
            $display("FAIL stereo_info got=%h required=%h", {bus.frame_channels, bus.frame_rate}, {8'd2, last_rate}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        longint t0;
        int cyc;
        do_reset();
        add_file_hdr(32'd100); add_frame(1, 100, 0);
        add_file_hdr(32'd100); add_frame(1, 100, 0);
        t0 = $time;
        send_all(ok);
        cyc = int'(($time - t0) / 10);
        wait_drain();
        // 18 words at one per clock plus one bubble while the first file's last slice drains.
        total_cnt++; if (cyc != 19) $display("FAIL b2b_cycles got=%0d required=19", cyc); else pass_cnt++;
        total_cnt++; if (exp_sl.size() != 0 || obs_done != 2) $display("FAIL b2b_stream got=%0d,%0d required=0,2", exp_sl.size(), obs_done); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok, rdy_bad, data_bad;
        logic [63:0] held;
        int c;
        do_reset();
        add_file_hdr(32'd100);
        add_frame(1, 100, 0);
        rdy_bad = 1'b0;
        data_bad = 1'b0;
        fork
            send_all(ok);
            begin
                c = 0;
                @(negedge clk);
                while (!bus.slice_valid && c < 200) begin c++; @(negedge clk); end
                rdy_mode = 2;
                repeat (2) @(negedge clk);
                held = bus.slice_data;
                repeat (10) begin
                    @(negedge clk);
                    if (bus.in_ready !== 1'b0 || bus.slice_valid !== 1'b1) rdy_bad = 1'b1;
                    if (bus.slice_data !== held) data_bad = 1'b1;
                end
                rdy_mode = 0;
            end
        join
        wait_drain();
        total_cnt++; if (rdy_bad) $display("FAIL stall_in_ready got=ready required=blocked"); else pass_cnt++;
        total_cnt++; if (data_bad) $display("FAIL stall_data got=changed required=stable"); else pass_cnt++;
        total_cnt++; if (ok !== 1'b1 || exp_sl.size() != 0) $display("FAIL stall_stream got=%0d left required=0", exp_sl.size()); else pass_cnt++;
    endtask

    task automatic test_random();
        bit ok;
        int nf, sum;
        int fsl[3];
        do_reset();
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            nf = $urandom_range(1, 3);
            sum = 0;
            for (int i = 0; i < nf; i++) begin fsl[i] = pick_fs(); sum += fsl[i]; end
            add_file_hdr(32'(sum));
            for (int i = 0; i < nf; i++) add_frame($urandom_range(1, MAX_CH), fsl[i], 0);
        end
        send_all(ok);
        wait_drain();
        total_cnt++; if (ok !== 1'b1 || bus.error !== 1'b0) $display("FAIL rand_files got=ok%b err%b required=ok1 err0", ok, bus.error); else pass_cnt++;
        total_cnt++; if (exp_sl.size() + exp_lms.size() != 0) $display("FAIL rand_left got=%0d required=0", exp_sl.size() + exp_lms.size()); else pass_cnt++;
        total_cnt++; if (obs_done != exp_done) $display("FAIL rand_done got=%0d required=%0d", obs_done, exp_done); else pass_cnt++;
        total_cnt++; if ({bus.frame_channels, bus.frame_rate} !== {8'(last_nch), last_rate})
            $display("FAIL rand_info got=%h required=%h", {bus.frame_channels, bus.frame_rate}, {8'(last_nch), last_rate}); else pass_cnt++;

        do_reset();
        rdy_mode = 1;
        add_file_hdr(32'd0);
        add_frame(1, 5120, 0);
        add_frame(2, pick_fs(), 0);
        add_frame(MAX_CH, 20, 0);
        send_all(ok);
        wait_drain();
        total_cnt++; if (ok !== 1'b1 || bus.error !== 1'b0) $display("FAIL stream_file got=ok%b err%b required=ok1 err0", ok, bus.error); else pass_cnt++;
        total_cnt++; if (exp_sl.size() + exp_lms.size() != 0 || obs_done != 3)
            $display("FAIL stream_left got=%0d,%0d required=0,3", exp_sl.size() + exp_lms.size(), obs_done); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL stream_wait_hdr got=%b required=1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_bad_magic();
        bit ok;
        do_reset();
        stim.push_back({32'h716f6167, 32'd0});
        send_all(ok);
        total_cnt++; if ({ok, bus.error, bus.in_ready} !== 3'b110) $display("FAIL magic_error got=%b required=110", {ok, bus.error, bus.in_ready}); else pass_cnt++;
        bus.in_data  = {MAGIC, 32'd40};
        bus.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        total_cnt++; if ({bus.error, bus.in_ready} !== 2'b10) $display("FAIL magic_sticky got=%b required=10", {bus.error, bus.in_ready}); else pass_cnt++;
    endtask

    task automatic test_bad_header();
        bit ok;
        int tch[5] = '{3, 0, 1, 1, 1};
        int tfs[5] = '{20, 20, 0, 5121, 30};
        int tt[5]  = '{100, 100, 100, 10000, 20};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            add_file_hdr(32'(tt[i]));
            stim.push_back({8'(tch[i]), 24'd44100, 16'(tfs[i]), 16'd64});
            send_all(ok);
            total_cnt++; if ({ok, bus.error, bus.in_ready} !== 3'b110)
                $display("FAIL bad_hdr_%0d got=%b required=110", i, {ok, bus.error, bus.in_ready}); else pass_cnt++;
        end
        // fs equal to the remaining sample count is legal.
        do_reset();
        add_file_hdr(32'd20);
        add_frame(1, 20, 0);
        send_all(ok);
        wait_drain();
        total_cnt++; if ({ok, bus.error} !== 2'b10 || obs_done != 1) $display("FAIL fs_eq_rem got=%b,%0d required=10,1", {ok, bus.error}, obs_done); else pass_cnt++;
    endtask

    task automatic test_bad_fsize();
        bit ok;
        int c;
        do_reset();
        add_file_hdr(32'd40);
        add_frame(1, 40, 8);
        send_all(ok);
        c = 0;
        while (bus.error !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
        total_cnt++; if ({ok, bus.error, bus.in_ready} !== 3'b110) $display("FAIL fsize_error got=%b required=110", {ok, bus.error, bus.in_ready}); else pass_cnt++;
        total_cnt++; if (exp_sl.size() != 0) $display("FAIL fsize_slices got=%0d left required=0", exp_sl.size()); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        bit ok;
        do_reset();
        rdy_mode = 3;
        add_file_hdr(32'd60);
        add_frame(2, 60, 0);
        while (stim.size() > 8) void'(stim.pop_back());
        send_all(ok);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if ({ok, bus.slice_valid, 8'(bus.slice_channel)} !== {2'b11, 8'd1})
            $display("FAIL mid_pending got=%h required=%h", {ok, bus.slice_valid, 8'(bus.slice_channel)}, {2'b11, 8'd1}); else pass_cnt++;
        rst = 1'b1;
        #2;
        total_cnt++; if ({bus.lms_valid, bus.slice_valid, bus.error, bus.in_ready} !== 4'b0001)
            $display("FAIL mid_rst_flags got=%b required=0001", {bus.lms_valid, bus.slice_valid, bus.error, bus.in_ready}); else pass_cnt++;
        total_cnt++; if ({bus.slice_data, bus.frame_channels} !== '0)
            $display("FAIL mid_rst_data got=%h required=0", {bus.slice_data, bus.frame_channels}); else pass_cnt++;
        do_reset();
        add_file_hdr(32'd40);
        add_frame(1, 40, 0);
        send_all(ok);
        wait_drain();
        total_cnt++; if ({ok, bus.error} !== 2'b10 || exp_sl.size() + exp_lms.size() != 0 || obs_done != 1)
            $display("FAIL mid_fresh got=%b,%0d,%0d required=10,0,1", {ok, bus.error}, exp_sl.size() + exp_lms.size(), obs_done); else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rdy_mode     = 0;
        exp_done     = 0;
        obs_done     = 0;
        obs_sl_cnt   = 0;
        last_rate    = '0;
        last_nch     = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_mono();
        test_stereo();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_bad_magic();
        test_bad_header();
        test_bad_fsize();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
